// File: rtl/can_bit_timing_if.sv
// Configuration, bus and timing-pulse signals between the bit-timing controller
// and the bit stream processor.
interface can_bit_timing_if #(
  parameter int BRP_W   = 8,
  parameter int TSEG1_W = 4,
  parameter int TSEG2_W = 3
);
  logic               en;
  logic [BRP_W-1:0]   brp;
  logic [TSEG1_W-1:0] tseg1;
  logic [TSEG2_W-1:0] tseg2;
  logic [1:0]         sjw;
  logic               hard_sync_en;
  logic               rx;
  logic               tq_tick;
  logic               sample_point;
  logic               sampled_bit;
  logic               tx_point;
  logic               hard_sync_done;
  logic [1:0]         seg;

  modport master (
    output en, brp, tseg1, tseg2, sjw, hard_sync_en, rx,
    input  tq_tick, sample_point, sampled_bit, tx_point, hard_sync_done, seg
  );
  modport slave (
    input  en, brp, tseg1, tseg2, sjw, hard_sync_en, rx,
    output tq_tick, sample_point, sampled_bit, tx_point, hard_sync_done, seg
  );
endinterface

// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: tq prescaler, SYNC/TSEG1/TSEG2 sequencing,
// hard sync and SJW-limited resynchronisation on recessive-to-dominant edges.
module can_bit_timing #(
  parameter int BRP_W   = 8,
  parameter int TSEG1_W = 4,
  parameter int TSEG2_W = 3
) (
  input logic              clk,
  input logic              reset,
  can_bit_timing_if.slave  bus
);
  // Counter wide enough for tseg1+1 plus the largest extension (4 tq) without wrap.
  localparam int QW = ((TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, TSEG1 = 2'd2, TSEG2 = 2'd3} seg_t;

  seg_t               seg_q, seg_d;
  logic [BRP_W-1:0]   pcnt_q, pcnt_d, brp_l;
  logic [QW-1:0]      qcnt_q, qcnt_d, ext_q, ext_d, shr_q, shr_d;
  logic [TSEG1_W-1:0] tseg1_l;
  logic [TSEG2_W-1:0] tseg2_l;
  logic [1:0]         sjw_l;
  logic               rx_prev, lock_q, lock_d;
  logic               sp_q, sp_d, tx_q, tx_d, hs_q, hs_d, sbit_q;
  logic               latch, cap, early, tick, edge_det;
  logic [QW-1:0]      sjw1, qinc, rem;

  assign tick     = (seg_q != IDLE) && (pcnt_q == brp_l);
  assign edge_det = rx_prev & ~bus.rx;
  assign sjw1     = QW'(sjw_l) + 1'b1;
  assign qinc     = qcnt_q + 1'b1;
  assign rem      = QW'(tseg2_l) + 1'b1 - qcnt_q;

  always_comb begin
    seg_d  = seg_q;
    pcnt_d = pcnt_q;
    qcnt_d = qcnt_q;
    ext_d  = ext_q;
    shr_d  = shr_q;
    lock_d = lock_q;
    sp_d   = 1'b0;
    tx_d   = 1'b0;
    hs_d   = 1'b0;
    latch  = 1'b0;
    cap    = 1'b0;
    early  = 1'b0;
    if (!bus.en) begin
      seg_d  = IDLE;
      pcnt_d = '0;
      qcnt_d = '0;
      ext_d  = '0;
      shr_d  = '0;
      lock_d = 1'b0;
    end else if (edge_det && bus.hard_sync_en) begin
      // Hard sync: the edge itself is the SYNC segment, so restart in TSEG1.
      seg_d  = TSEG1;
      pcnt_d = '0;
      qcnt_d = '0;
      ext_d  = '0;
      shr_d  = '0;
      lock_d = 1'b1;
      latch  = 1'b1;
      hs_d   = 1'b1;
      tx_d   = 1'b1;
    end else begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      unique case (seg_q)
        IDLE: begin
          seg_d  = SYNC;
          pcnt_d = '0;
          qcnt_d = '0;
          ext_d  = '0;
          shr_d  = '0;
          latch  = 1'b1;
          tx_d   = 1'b1;
        end
        SYNC: begin
          if (edge_det && !lock_q) lock_d = 1'b1;
          if (tick) begin
            seg_d  = TSEG1;
            qcnt_d = '0;
            ext_d  = '0;
            shr_d  = '0;
          end
        end
        TSEG1: begin
          if (edge_det && !lock_q) begin
            ext_d  = (qinc < sjw1) ? qinc : sjw1;
            lock_d = 1'b1;
          end
          // End test uses the updated ext so a late edge on the last tick still lengthens.
          if (tick) begin
            if (qcnt_q == QW'(tseg1_l) + ext_d) begin
              seg_d  = TSEG2;
              qcnt_d = '0;
              sp_d   = 1'b1;
              cap    = 1'b1;
              lock_d = 1'b0;
            end else begin
              qcnt_d = qinc;
            end
          end
        end
        TSEG2: begin
          if (edge_det && !lock_q) begin
            lock_d = 1'b1;
            if (rem <= sjw1) early = 1'b1;
            else             shr_d = sjw1;
          end
          if (early) begin
            seg_d  = TSEG1;
            pcnt_d = '0;
            qcnt_d = '0;
            ext_d  = '0;
            shr_d  = '0;
            tx_d   = 1'b1;
          end else if (tick) begin
            if (qcnt_q + shr_d >= QW'(tseg2_l)) begin
              seg_d  = SYNC;
              qcnt_d = '0;
              ext_d  = '0;
              shr_d  = '0;
              latch  = 1'b1;
              tx_d   = 1'b1;
            end else begin
              qcnt_d = qinc;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q   <= IDLE;
      pcnt_q  <= '0;
      qcnt_q  <= '0;
      ext_q   <= '0;
      shr_q   <= '0;
      lock_q  <= 1'b0;
      rx_prev <= 1'b1;
      sp_q    <= 1'b0;
      tx_q    <= 1'b0;
      hs_q    <= 1'b0;
      sbit_q  <= 1'b1;
      brp_l   <= '0;
      tseg1_l <= '0;
      tseg2_l <= '0;
      sjw_l   <= '0;
    end else begin
      seg_q   <= seg_d;
      pcnt_q  <= pcnt_d;
      qcnt_q  <= qcnt_d;
      ext_q   <= ext_d;
      shr_q   <= shr_d;
      lock_q  <= lock_d;
      rx_prev <= bus.rx;
      sp_q    <= sp_d;
      tx_q    <= tx_d;
      hs_q    <= hs_d;
      if (cap) sbit_q <= bus.rx;
      if (latch) begin
        brp_l   <= bus.brp;
        tseg1_l <= bus.tseg1;
        tseg2_l <= bus.tseg2;
        sjw_l   <= bus.sjw;
      end
    end
  end

  assign bus.tq_tick        = tick;
  assign bus.sample_point   = sp_q;
  assign bus.sampled_bit    = sbit_q;
  assign bus.tx_point       = tx_q;
  assign bus.hard_sync_done = hs_q;
  assign bus.seg            = seg_q;
endmodule

// File: tb/tb_can_bit_timing.sv
// Self-checking bench for can_bit_timing: table-driven nominal bits plus
// hand-written sync/resync/disable/reset sequences, checked through a scoreboard queue.
module tb_can_bit_timing;
  localparam int BRP_W = 8, TSEG1_W = 4, TSEG2_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  can_bit_timing_if #(.BRP_W(BRP_W), .TSEG1_W(TSEG1_W), .TSEG2_W(TSEG2_W)) bus ();

  can_bit_timing #(.BRP_W(BRP_W), .TSEG1_W(TSEG1_W), .TSEG2_W(TSEG2_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct { string nm; int v; } exp_t;
  exp_t sb[$];

  typedef struct { int brp; int tseg1; int tseg2; int bit_len; int sp_ofs; } vec_t;
  vec_t tbl[5];

  task automatic expect_v(input string nm, input int v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic check(input int act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d with nothing expected", act);
    end else begin
      e = sb.pop_front();
      if (act != e.v) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.nm, act, e.v);
      end
    end
  endtask

  function automatic logic pulse_of(input int sel);
    case (sel)
      0:       return bus.tx_point;
      1:       return bus.sample_point;
      default: return bus.hard_sync_done;
    endcase
  endfunction

  // Returns the cycle number at which the pulse is seen, or -1 on timeout.
  task automatic wait_pulse(input int sel, input int limit, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (pulse_of(sel)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) $display("FAIL timeout: pulse %0d not seen within %0d cycles", sel, limit);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart(input int b, input int t1, input int t2, input int s, output int t0);
    int e;
    bus.en = 1'b0;
    cycles(2);
    bus.brp   = BRP_W'(b);
    bus.tseg1 = TSEG1_W'(t1);
    bus.tseg2 = TSEG2_W'(t2);
    bus.sjw   = 2'(s);
    bus.en    = 1'b1;
    e = cyc;
    expect_v("en_to_tx_latency", 1);
    wait_pulse(0, 10, t0);
    check(t0 - e);
  endtask

  initial begin
    int t0, t1, t2, t3;

    tbl[0] = '{19, 5, 2, 200, 140};
    tbl[1] = '{9,  5, 2, 100, 70};
    tbl[2] = '{0,  0, 0, 3,   2};
    tbl[3] = '{1, 15, 7, 50,  34};
    tbl[4] = '{3,  3, 1, 28,  20};

    bus.en = 1'b0; bus.brp = '0; bus.tseg1 = '0; bus.tseg2 = '0; bus.sjw = '0;
    bus.hard_sync_en = 1'b0; bus.rx = 1'b1;

    // Reset state
    cycles(3);
    expect_v("rst_seg", 0);         check(int'(bus.seg));
    expect_v("rst_pulses", 0);
    check(int'({bus.tq_tick, bus.sample_point, bus.tx_point, bus.hard_sync_done}));
    expect_v("rst_sampled_bit", 1); check(int'(bus.sampled_bit));
    reset = 1'b0;
    cycles(2);
    expect_v("disabled_seg", 0);    check(int'(bus.seg));

    // Nominal bits from the table
    foreach (tbl[i]) begin
      restart(tbl[i].brp, tbl[i].tseg1, tbl[i].tseg2, 0, t0);
      expect_v("nom_seg_at_tx", 1);       check(int'(bus.seg));
      expect_v("nom_sp_ofs", tbl[i].sp_ofs);
      wait_pulse(1, 400, t1);              check(t1 - t0);
      expect_v("nom_seg_at_sp", 3);       check(int'(bus.seg));
      expect_v("nom_tq_tick_at_sp", (tbl[i].brp == 0) ? 1 : 0);
      check(int'(bus.tq_tick));
      expect_v("nom_sp_to_tx", tbl[i].bit_len - tbl[i].sp_ofs);
      wait_pulse(0, 400, t2);              check(t2 - t1);
      expect_v("nom_bit_len", tbl[i].bit_len);
      wait_pulse(0, 400, t3);              check(t3 - t2);
    end

    // Hard sync at clk 57 of a bit
    restart(19, 5, 2, 0, t0);
    cycles(57);
    bus.rx = 1'b0; bus.hard_sync_en = 1'b1;
    expect_v("hs_done_time", 58);
    wait_pulse(2, 100, t1);                check(t1 - t0);
    expect_v("hs_tx_point", 1);            check(int'(bus.tx_point));
    expect_v("hs_seg", 2);                 check(int'(bus.seg));
    expect_v("hs_to_sp", 120);
    wait_pulse(1, 400, t2);                check(t2 - t1);
    expect_v("hs_sampled_bit", 0);         check(int'(bus.sampled_bit));
    bus.rx = 1'b1; bus.hard_sync_en = 1'b0;
    expect_v("hs_sp_to_tx", 60);
    wait_pulse(0, 400, t3);                check(t3 - t2);

    // Late edge in TSEG1 qcnt=3, sjw=1; a second edge in the same bit is ignored
    restart(9, 5, 2, 1, t0);
    cycles(45); bus.rx = 1'b0;
    cycles(5);  bus.rx = 1'b1;
    cycles(10); bus.rx = 1'b0;
    expect_v("ext_sp_ofs", 90);
    wait_pulse(1, 400, t1);                check(t1 - t0);
    bus.rx = 1'b1;
    expect_v("ext_bit_len", 120);
    wait_pulse(0, 400, t2);                check(t2 - t0);
    expect_v("ext_next_bit", 100);
    wait_pulse(0, 400, t3);                check(t3 - t2);

    // Longest TSEG1: 16 tq plus 4 tq extension, brp=0
    restart(0, 15, 7, 3, t0);
    cycles(6); bus.rx = 1'b0;
    expect_v("max_tseg1_sp", 21);
    wait_pulse(1, 100, t1);                check(t1 - t0);
    bus.rx = 1'b1;
    expect_v("max_tseg1_bit", 29);
    wait_pulse(0, 100, t2);                check(t2 - t0);

    // Edge in TSEG2 qcnt=2, sjw=1: bit ends at once, SYNC skipped
    restart(9, 5, 2, 1, t0);
    cycles(92); bus.rx = 1'b0;
    expect_v("early_tx", 93);
    wait_pulse(0, 100, t1);                check(t1 - t0);
    expect_v("early_seg", 2);              check(int'(bus.seg));
    expect_v("early_sp", 60);
    wait_pulse(1, 400, t2);                check(t2 - t1);
    bus.rx = 1'b1;
    expect_v("early_next_tx", 30);
    wait_pulse(0, 400, t3);                check(t3 - t2);

    // Edge in TSEG2 qcnt=0, sjw=0: phase2 shortened by one tq
    restart(9, 5, 2, 0, t0);
    cycles(75); bus.rx = 1'b0;
    expect_v("shr_bit_len", 90);
    wait_pulse(0, 200, t1);                check(t1 - t0);
    bus.rx = 1'b1;

    // Prescaler change mid-bit takes effect on the next bit
    restart(9, 5, 2, 0, t0);
    cycles(30); bus.brp = 8'd4;
    expect_v("brp_cur_bit", 100);
    wait_pulse(0, 400, t1);                check(t1 - t0);
    expect_v("brp_next_bit", 50);
    wait_pulse(0, 400, t2);                check(t2 - t1);

    // Extension clipped by sjw=0, dominant sample, then disable mid-TSEG1
    restart(9, 5, 2, 0, t0);
    cycles(30); bus.rx = 1'b0;
    expect_v("clip_sp", 80);
    wait_pulse(1, 400, t1);                check(t1 - t0);
    expect_v("clip_sampled", 0);           check(int'(bus.sampled_bit));
    expect_v("clip_bit_len", 110);
    wait_pulse(0, 400, t2);                check(t2 - t0);
    cycles(30);
    bus.en = 1'b0; bus.rx = 1'b1;
    cycles(1);
    expect_v("dis_seg", 0);                check(int'(bus.seg));
    expect_v("dis_pulses", 0);
    check(int'({bus.tq_tick, bus.sample_point, bus.tx_point, bus.hard_sync_done}));
    expect_v("dis_sampled_hold", 0);       check(int'(bus.sampled_bit));
    cycles(1);
    bus.en = 1'b1;
    t3 = cyc;
    expect_v("reen_tx_latency", 1);
    wait_pulse(0, 10, t0);                 check(t0 - t3);
    expect_v("reen_seg", 1);               check(int'(bus.seg));
    expect_v("reen_sp", 70);
    wait_pulse(1, 400, t1);                check(t1 - t0);
    expect_v("reen_sampled", 1);           check(int'(bus.sampled_bit));

    // Asynchronous reset mid-bit
    cycles(12);
    #2 reset = 1'b1;
    #1;
    expect_v("arst_seg", 0);               check(int'(bus.seg));
    expect_v("arst_pulses", 0);
    check(int'({bus.tq_tick, bus.sample_point, bus.tx_point, bus.hard_sync_done}));
    @(negedge clk);
    reset = 1'b0;
    t3 = cyc;
    expect_v("arst_tx_latency", 1);
    wait_pulse(0, 10, t0);                 check(t0 - t3);
    expect_v("arst_sp", 70);
    wait_pulse(1, 400, t1);                check(t1 - t0);
    expect_v("arst_bit", 100);
    wait_pulse(0, 400, t2);                check(t2 - t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
